ascii_case_stream: RTL and testbench

//  Streaming character stage that feeds the 8-bit case converter path.

---
 rtl/ascii_case_stream_if.sv | 11 +
 rtl/ascii_case_stream.sv | 126 ++++++++++++
 tb/tb_ascii_case_stream.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_case_stream_if.sv
// Byte stream with frame marker: valid/ready handshake carrying an 8-bit character and a last-of-frame flag.
// The master drives valid/data/last and the slave drives ready.
interface ascii_case_stream_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ascii_case_stream.sv
// Per-frame ASCII case conversion into a DEPTH-entry FIFO; 1-cycle latency when empty.
// Backpressure: in ready only when the FIFO is not full (no pass-through on a same-cycle pop); head holds while stalled.
module ascii_case_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    ascii_case_stream_if.slave  in_s,
    ascii_case_stream_if.master out_s,
    input  logic [1:0]          mode,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    byte_cnt,
    output logic [CNT_W-1:0]    conv_cnt,
    output logic [CNT_W-1:0]    frame_cnt
);
    localparam int               AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [1:0]    eff_mode;
    logic [7:0]    conv_dat;
    logic          changed;

    // Mode bit 0 enables lower->upper, bit 1 enables upper->lower; 11 therefore swaps.
    function automatic logic [7:0] convert(input logic [7:0] b, input logic [1:0] m);
        logic       is_lower;
        logic       is_upper;
        logic [7:0] r;
        is_lower = (b >= 8'h61) && (b <= 8'h7A);
        is_upper = (b >= 8'h41) && (b <= 8'h5A);
        r = b;
        if (is_lower && m[0]) r = b - 8'h20;
        if (is_upper && m[1]) r = b + 8'h20;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign in_s.ready  = !full && !rst;
    assign out_s.valid = !empty;
    assign push        = in_s.valid && in_s.ready;
    assign pop         = out_s.valid && out_s.ready;
    assign out_s.data  = mem[rd_ptr][7:0];
    assign out_s.last  = mem[rd_ptr][8];

    // The first byte of a frame uses the live mode; later bytes use the one latched with it.
    assign eff_mode = (state == IDLE) ? mode : mode_q;
    assign conv_dat = convert(in_s.data, eff_mode);
    assign changed  = (conv_dat != in_s.data);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_s.last, conv_dat};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 2'b00;
        end else if (push) begin
            case (state)
                IDLE: begin
                    mode_q <= mode;
                    if (!in_s.last) state <= FRAME;
                end
                FRAME: begin
                    if (in_s.last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            conv_cnt  <= '0;
            frame_cnt <= '0;
        end else if (clr_stats) begin
            byte_cnt  <= '0;
            conv_cnt  <= '0;
            frame_cnt <= '0;
        end else if (push) begin
            byte_cnt <= sat_inc(byte_cnt);
            if (changed)   conv_cnt  <= sat_inc(conv_cnt);
            if (in_s.last) frame_cnt <= sat_inc(frame_cnt);
        end
    end
endmodule

// File: tb/tb_ascii_case_stream.sv
// Directed bench: a queue-based reference model checked every cycle, plus literal expectations per scenario.
module tb_ascii_case_stream;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             clr_stats;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] conv_cnt;
    logic [CNT_W-1:0] frame_cnt;

    ascii_case_stream_if in_if ();
    ascii_case_stream_if out_if ();

    ascii_case_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_s      (in_if),
        .out_s     (out_if),
        .mode      (mode),
        .clr_stats (clr_stats),
        .byte_cnt  (byte_cnt),
        .conv_cnt  (conv_cnt),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents, frame tracking and counters.
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    int         m_byte = 0;
    int         m_conv = 0;
    int         m_frame = 0;
    bit         m_in_frame = 0;
    logic [1:0] m_fmode = 2'b00;
    bit         m_push;
    bit         m_pop;
    logic [1:0] m_mode;
    logic [7:0] m_c;

    function automatic logic [7:0] model_conv(input logic [7:0] b, input logic [1:0] m);
        bit lo;
        bit up;
        lo = b inside {[8'h61:8'h7A]};
        up = b inside {[8'h41:8'h5A]};
        case (m)
            2'b01:   return lo ? b - 8'h20 : b;
            2'b10:   return up ? b + 8'h20 : b;
            2'b11:   return lo ? b - 8'h20 : (up ? b + 8'h20 : b);
            default: return b;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_in_frame = 0;
            m_fmode    = 2'b00;
            m_byte     = 0;
            m_conv     = 0;
            m_frame    = 0;
        end else begin
            m_push = in_if.valid && (exp_q.size() < DEPTH);
            m_pop  = out_if.ready && (exp_q.size() > 0);
            if (out_if.valid && out_if.ready) got_q.push_back({out_if.last, out_if.data});
            if (m_pop) void'(exp_q.pop_front());
            m_c = in_if.data;
            if (m_push) begin
                m_mode = m_in_frame ? m_fmode : mode;
                m_c    = model_conv(in_if.data, m_mode);
                exp_q.push_back({in_if.last, m_c});
                if (!m_in_frame && !in_if.last) begin
                    m_in_frame = 1;
                    m_fmode    = mode;
                end else if (m_in_frame && in_if.last) begin
                    m_in_frame = 0;
                end
            end
            if (clr_stats) begin
                m_byte  = 0;
                m_conv  = 0;
                m_frame = 0;
            end else if (m_push) begin
                m_byte = sat(m_byte + 1);
                if (m_c != in_if.data) m_conv = sat(m_conv + 1);
                if (in_if.last) m_frame = sat(m_frame + 1);
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_if.ready, (!rst && exp_q.size() < DEPTH));
        check("out_valid", out_if.valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_data", out_if.data, exp_q[0][7:0]);
            check("out_last", out_if.last, exp_q[0][8]);
        end
        check("byte_cnt", byte_cnt, m_byte);
        check("conv_cnt", conv_cnt, m_conv);
        check("frame_cnt", frame_cnt, m_frame);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] m);
        int   n;
        logic acc;
        n = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.last  = l;
        mode        = m;
        do begin
            acc = in_if.ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        check("send_accept", acc, 1'b1);
        in_if.valid = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [7:0] exp[$], input int lmask);
        check({name, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), got_q[i][7:0], exp[i]);
            check($sformatf("%s_last%0d", name, i), got_q[i][8], lmask[i]);
        end
    endtask

    logic [7:0] ev [$];
    logic [7:0] in_bytes [$];

    initial begin
        rst          = 1'b0;
        mode         = 2'b00;
        clr_stats    = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = 8'h00;
        in_if.last   = 1'b0;
        out_if.ready = 1'b0;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // T1: reset with the FIFO half full
        send(8'h11, 1'b0, 2'b00);
        send(8'h22, 1'b0, 2'b00);
        check("t1_pre_valid", out_if.valid, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t1_rst_valid", out_if.valid, 1'b0);
        check("t1_rst_ready", in_if.ready, 1'b0);
        check("t1_rst_bytes", byte_cnt, 0);
        tick(2);
        rst = 1'b0;
        #1;
        check("t1_post_ready", in_if.ready, 1'b1);
        tick(1);

        // T2: "hello" in upper mode
        clear_stats();
        got_q.delete();
        out_if.ready = 1'b1;
        in_bytes = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        foreach (in_bytes[i]) send(in_bytes[i], (i == 4), 2'b01);
        tick(4);
        ev = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        check_log("t2", ev, 32'h10);
        check("t2_bytes", byte_cnt, 5);
        check("t2_conv", conv_cnt, 5);
        check("t2_frames", frame_cnt, 1);

        // T3: range boundaries in upper mode
        clear_stats();
        got_q.delete();
        in_bytes = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
        foreach (in_bytes[i]) send(in_bytes[i], (i == 7), 2'b01);
        tick(4);
        ev = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h41, 8'h5A, 8'h7B};
        check_log("t3", ev, 32'h80);
        check("t3_conv", conv_cnt, 2);

        // T4: fill, overfill, drain across three refills so the pointers wrap
        for (int r = 0; r < 3; r++) begin
            got_q.delete();
            ev.delete();
            out_if.ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                send(8'h30 + 8'(r * 8 + i), (r != 0 && i == DEPTH - 1), 2'b00);
                ev.push_back(8'h30 + 8'(r * 8 + i));
            end
            check("t4_full_ready", in_if.ready, 1'b0);
            if (r == 0) begin
                ev.push_back(8'h3F);
                fork
                    send(8'h3F, 1'b1, 2'b00);
                    begin
                        tick(3);
                        out_if.ready = 1'b1;
                    end
                join
            end else begin
                out_if.ready = 1'b1;
            end
            tick(8);
            check_log($sformatf("t4_r%0d", r), ev, (r == 0) ? 32'h10 : 32'h08);
        end

        // T5: mode change mid-frame is ignored until the next frame
        got_q.delete();
        send(8'h41, 1'b0, 2'b10);
        send(8'h62, 1'b0, 2'b01);
        send(8'h43, 1'b1, 2'b01);
        send(8'h61, 1'b1, 2'b01);
        tick(4);
        ev = '{8'h61, 8'h62, 8'h63, 8'h41};
        check_log("t5", ev, 32'h0C);

        // Swap mode over a mixed frame
        got_q.delete();
        in_bytes = '{8'h61, 8'h5A, 8'h39, 8'h80};
        foreach (in_bytes[i]) send(in_bytes[i], (i == 3), 2'b11);
        tick(4);
        ev = '{8'h41, 8'h7A, 8'h39, 8'h80};
        check_log("swap", ev, 32'h08);

        // T6: counter saturation and clear-over-increment priority
        clear_stats();
        for (int i = 0; i < 20; i++) send(8'h61, 1'b1, 2'b01);
        tick(2);
        check("t6_bytes_sat", byte_cnt, CMAX);
        check("t6_conv_sat", conv_cnt, CMAX);
        check("t6_frames_sat", frame_cnt, CMAX);
        clr_stats = 1'b1;
        send(8'h62, 1'b1, 2'b01);
        clr_stats = 1'b0;
        check("t6_clr_bytes", byte_cnt, 0);
        check("t6_clr_conv", conv_cnt, 0);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
